// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues reads to a 1-cycle synchronous
// instruction memory and presents fetched instructions to IF/ID. A one-entry
// hold buffer absorbs the word returning during a stall; a branch redirect
// kills whatever is presented, held or in flight.
module fetch_stage #(
  parameter int unsigned     N        = 32,
  parameter int unsigned     AW       = 32,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter logic [AW-1:0]   PC_STEP  = AW'(4)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          stall_i,
  input  logic          halt_i,
  input  logic          branch_taken_i,
  input  logic [AW-1:0] branch_target_i,
  output logic          imem_rd_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic [N-1:0]  imem_data_i,
  output logic [N-1:0]  instruction_o,
  output logic [AW-1:0] pc_o,
  output logic          valid_o
);

  logic [AW-1:0] r_pc;
  logic          r_req;
  logic [AW-1:0] r_req_pc;
  logic          r_hold_v;
  logic [N-1:0]  r_hold_data;
  logic [AW-1:0] r_hold_pc;

  logic          w_issue;
  logic [AW-1:0] w_addr;

  // Issue decision and read address; a branch overrides both stall and halt.
  always_comb begin
    w_issue     = branch_taken_i | (~halt_i & ~stall_i);
    w_addr      = branch_taken_i ? branch_target_i : r_pc;
    imem_rd_o   = w_issue & ~RST;
    imem_addr_o = w_addr;
  end

  // Output select: hold buffer first, then the returning read; nothing during a redirect.
  always_comb begin
    valid_o       = 1'b0;
    instruction_o = '0;
    pc_o          = '0;
    if (!branch_taken_i) begin
      if (r_hold_v) begin
        valid_o       = 1'b1;
        instruction_o = r_hold_data;
        pc_o          = r_hold_pc;
      end else if (r_req) begin
        valid_o       = 1'b1;
        instruction_o = imem_data_i;
        pc_o          = r_req_pc;
      end
    end
  end

  // PC, in-flight request tracking and hold-buffer capture/release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc        <= RESET_PC;
      r_req       <= 1'b0;
      r_req_pc    <= '0;
      r_hold_v    <= 1'b0;
      r_hold_data <= '0;
      r_hold_pc   <= '0;
    end else begin
      if (w_issue) begin
        r_pc     <= w_addr + PC_STEP;
        r_req    <= 1'b1;
        r_req_pc <= w_addr;
      end else begin
        r_req    <= 1'b0;
      end

      // A stall with no issue guarantees the captured word is the only one pending.
      if (branch_taken_i || !stall_i) begin
        r_hold_v <= 1'b0;
      end else if (r_req && !r_hold_v) begin
        r_hold_v    <= 1'b1;
        r_hold_data <= imem_data_i;
        r_hold_pc   <= r_req_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, wrap/reset sequence on a
// second instance, and randomized traffic against a one-slot pending model.
module tb_fetch_stage;

  logic        CLK;
  logic        RST;
  logic        stall_i, halt_i, br_i;
  logic [31:0] tgt_i;

  logic        a_rd, a_valid;
  logic [31:0] a_addr, a_data, a_instr, a_pc;
  logic        b_rd, b_valid;
  logic [31:0] b_addr, b_data, b_instr, b_pc;

  int vectors;
  int miscompares;

  fetch_stage #(.N(32), .AW(32), .RESET_PC(32'h0), .PC_STEP(32'd4)) u_a (
    .CLK(CLK), .RST(RST), .stall_i(stall_i), .halt_i(halt_i),
    .branch_taken_i(br_i), .branch_target_i(tgt_i),
    .imem_rd_o(a_rd), .imem_addr_o(a_addr), .imem_data_i(a_data),
    .instruction_o(a_instr), .pc_o(a_pc), .valid_o(a_valid));

  fetch_stage #(.N(32), .AW(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) u_b (
    .CLK(CLK), .RST(RST), .stall_i(stall_i), .halt_i(halt_i),
    .branch_taken_i(br_i), .branch_target_i(tgt_i),
    .imem_rd_o(b_rd), .imem_addr_o(b_addr), .imem_data_i(b_data),
    .instruction_o(b_instr), .pc_o(b_pc), .valid_o(b_valid));

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Synchronous memories; garbage on non-read cycles so stale data is visible.
  always @(posedge CLK) a_data <= a_rd ? memf(a_addr) : $urandom();
  always @(posedge CLK) b_data <= b_rd ? memf(b_addr) : $urandom();

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        s, h, b;
    logic [31:0] t;
    logic        ev;
    logic [31:0] epc;
    logic        erd;
    logic [31:0] eaddr;
  } vec_t;

  // Drive inputs at a negedge, check 1 time unit later, end at the next negedge.
  task automatic step(input string nm, input int sel,
                      input logic s, input logic h, input logic b, input logic [31:0] t,
                      input logic ev, input logic [31:0] epc,
                      input logic erd, input logic [31:0] eaddr);
    logic        v, rd;
    logic [31:0] pc, ins, ad, xpc, xins;
    stall_i = s; halt_i = h; br_i = b; tgt_i = t;
    #1;
    if (sel == 0) begin v = a_valid; pc = a_pc; ins = a_instr; rd = a_rd; ad = a_addr; end
    else          begin v = b_valid; pc = b_pc; ins = b_instr; rd = b_rd; ad = b_addr; end
    xpc  = ev ? epc : 32'h0;
    xins = ev ? memf(epc) : 32'h0;
    vectors++;
    if (v !== ev || pc !== xpc || ins !== xins || rd !== erd || ad !== eaddr) begin
      miscompares++;
      $display("FAIL %s: got valid=%0b pc=%h instr=%h rd=%0b addr=%h, expected valid=%0b pc=%h instr=%h rd=%0b addr=%h",
               nm, v, pc, ins, rd, ad, ev, xpc, xins, erd, eaddr);
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; stall_i = 1'b0; halt_i = 1'b0; br_i = 1'b0; tgt_i = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  vec_t tbl[24];

  initial begin
    logic        m_pv;
    logic [31:0] m_ppc, m_next;
    logic        s, h, b, ev, erd;
    logic [31:0] t, eaddr;
    logic        v, rd;
    logic [31:0] pc, ins, ad;

    vectors = 0; miscompares = 0;
    RST = 1'b1; stall_i = 1'b0; halt_i = 1'b0; br_i = 1'b0; tgt_i = '0;

    //          s  h  b  tgt         ev epc          rd addr
    tbl[0]  = '{0, 0, 0, 32'h0,      0, 32'h0,       1, 32'h0};
    tbl[1]  = '{0, 0, 0, 32'h0,      1, 32'h0,       1, 32'h4};
    tbl[2]  = '{0, 0, 0, 32'h0,      1, 32'h4,       1, 32'h8};
    tbl[3]  = '{1, 0, 0, 32'h0,      1, 32'h8,       0, 32'hC};
    tbl[4]  = '{1, 0, 0, 32'h0,      1, 32'h8,       0, 32'hC};
    tbl[5]  = '{1, 0, 0, 32'h0,      1, 32'h8,       0, 32'hC};
    tbl[6]  = '{0, 0, 0, 32'h0,      1, 32'h8,       1, 32'hC};
    tbl[7]  = '{0, 0, 1, 32'h40,     0, 32'h0,       1, 32'h40};
    tbl[8]  = '{0, 0, 0, 32'h0,      1, 32'h40,      1, 32'h44};
    tbl[9]  = '{1, 0, 0, 32'h0,      1, 32'h44,      0, 32'h48};
    tbl[10] = '{1, 0, 1, 32'h80,     0, 32'h0,       1, 32'h80};
    tbl[11] = '{0, 0, 0, 32'h0,      1, 32'h80,      1, 32'h84};
    tbl[12] = '{0, 1, 0, 32'h0,      1, 32'h84,      0, 32'h88};
    tbl[13] = '{0, 1, 0, 32'h0,      0, 32'h0,       0, 32'h88};
    tbl[14] = '{0, 0, 0, 32'h0,      0, 32'h0,       1, 32'h88};
    tbl[15] = '{0, 0, 0, 32'h0,      1, 32'h88,      1, 32'h8C};
    tbl[16] = '{0, 1, 1, 32'h100,    0, 32'h0,       1, 32'h100};
    tbl[17] = '{0, 1, 0, 32'h0,      1, 32'h100,     0, 32'h104};
    tbl[18] = '{1, 0, 0, 32'h0,      0, 32'h0,       0, 32'h104};
    tbl[19] = '{0, 0, 0, 32'h0,      0, 32'h0,       1, 32'h104};
    tbl[20] = '{0, 0, 0, 32'h0,      1, 32'h104,     1, 32'h108};
    tbl[21] = '{1, 1, 0, 32'h0,      1, 32'h108,     0, 32'h10C};
    tbl[22] = '{0, 1, 0, 32'h0,      1, 32'h108,     0, 32'h10C};
    tbl[23] = '{0, 0, 0, 32'h0,      0, 32'h0,       1, 32'h10C};

    // Directed table on the RESET_PC=0 instance.
    do_reset();
    for (int i = 0; i < 24; i++)
      step($sformatf("tbl[%0d]", i), 0, tbl[i].s, tbl[i].h, tbl[i].b, tbl[i].t,
           tbl[i].ev, tbl[i].epc, tbl[i].erd, tbl[i].eaddr);

    // PC wrap from 0xFFFF_FFFC, then async reset while a word is held.
    do_reset();
    step("wrap0", 1, 0, 0, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC);
    step("wrap1", 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0);
    step("wrap2", 1, 0, 0, 0, 0, 1, 32'h0,         1, 32'h4);
    step("hold0", 1, 1, 0, 0, 0, 1, 32'h4,         0, 32'h8);
    step("hold1", 1, 1, 0, 0, 0, 1, 32'h4,         0, 32'h8);
    stall_i = 1'b0; halt_i = 1'b0; br_i = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    v = b_valid; pc = b_pc; ins = b_instr; rd = b_rd; ad = b_addr;
    vectors++;
    if (v !== 1'b0 || pc !== 32'h0 || ins !== 32'h0 || rd !== 1'b0 || ad !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL rst_async: got valid=%0b pc=%h instr=%h rd=%0b addr=%h, expected 0 0 0 0 fffffffc",
               v, pc, ins, rd, ad);
    end
    @(negedge CLK);
    RST = 1'b0;
    step("refetch0", 1, 0, 0, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC);
    step("refetch1", 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0);

    // Randomized traffic against a single-pending-slot model.
    do_reset();
    m_pv = 1'b0; m_ppc = '0; m_next = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      s = ($urandom_range(0, 99) < 30);
      h = ($urandom_range(0, 99) < 20);
      b = ($urandom_range(0, 99) < 10);
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      if (!b) t = '0;
      ev    = m_pv && !b;
      erd   = b || (!h && !s);
      eaddr = b ? t : m_next;
      step($sformatf("rand[%0d]", n), 0, s, h, b, t, ev, m_ppc, erd, eaddr);
      if (b) begin
        m_pv = 1'b1; m_ppc = t; m_next = t + 32'd4;
      end else if (!m_pv || !s) begin
        if (erd) begin
          m_pv = 1'b1; m_ppc = eaddr; m_next = eaddr + 32'd4;
        end else begin
          m_pv = 1'b0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
